// File: rtl/input_conditioner.sv
// input_conditioner: front-end conditioning for the LC-3 board top level.
// Push-buttons are synchronized, debounced and turned into a rising-edge
// one-shot; slide switches are only synchronized. Every output is driven
// straight from a flop, so no input reaches an output combinationally.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SW_WIDTH        = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run_i,
   input  logic                continue_i,
   input  logic [SW_WIDTH-1:0] sw_i,
   output logic                run_o,
   output logic                run_pulse_o,
   output logic                continue_o,
   output logic                continue_pulse_o,
   output logic [SW_WIDTH-1:0] sw_o
);

   // Counter just wide enough to hold DEBOUNCE_CYCLES; it saturates by
   // construction because it clears when it reaches the last count.
   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Index 0 is run, index 1 is continue.
   localparam int NUM_BTN = 2;

   logic [NUM_BTN-1:0]  btn_raw;
   logic [NUM_BTN-1:0]  btn_s1;
   logic [NUM_BTN-1:0]  btn_s2;
   logic [NUM_BTN-1:0]  btn_level;
   logic [NUM_BTN-1:0]  btn_pulse;
   logic [CNT_W-1:0]    btn_cnt [NUM_BTN];
   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;

   assign btn_raw = {continue_i, run_i};

   // Two-flop synchronizers for buttons and switches; only s2 is used downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= btn_raw;
         btn_s2 <= btn_s1;
         sw_s1  <= sw_i;
         sw_s2  <= sw_s1;
      end
   end

   // Per-button debounce: the level flips only after DEBOUNCE_CYCLES
   // consecutive mismatching samples; any agreeing sample restarts the count.
   // The pulse is registered alongside the 0->1 flip so both appear together.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_level <= '0;
         btn_pulse <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            btn_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            btn_pulse[i] <= 1'b0;
            if (btn_s2[i] == btn_level[i]) begin
               btn_cnt[i] <= '0;
            end else if (btn_cnt[i] == CNT_LAST) begin
               btn_level[i] <= ~btn_level[i];
               btn_pulse[i] <= ~btn_level[i];
               btn_cnt[i]   <= '0;
            end else begin
               btn_cnt[i] <= btn_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign run_o            = btn_level[0];
   assign run_pulse_o      = btn_pulse[0];
   assign continue_o       = btn_level[1];
   assign continue_pulse_o = btn_pulse[1];
   assign sw_o             = sw_s2;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed testbench for input_conditioner. A DEBOUNCE_CYCLES=4 instance is
// the main device; a DEBOUNCE_CYCLES=1 instance shares the same inputs and is
// checked in the reset-mid-debounce scenario.
module tb_input_conditioner;

   logic        clk = 1'b0;
   logic        reset;
   logic        run_i;
   logic        continue_i;
   logic [15:0] sw_i;

   logic        run_o, run_pulse_o, continue_o, continue_pulse_o;
   logic [15:0] sw_o;
   logic        run1_o, run1_pulse_o, cont1_o, cont1_pulse_o;
   logic [15:0] sw1_o;

   int n_checks = 0;
   int n_fail   = 0;

   input_conditioner #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .run_i            (run_i),
      .continue_i       (continue_i),
      .sw_i             (sw_i),
      .run_o            (run_o),
      .run_pulse_o      (run_pulse_o),
      .continue_o       (continue_o),
      .continue_pulse_o (continue_pulse_o),
      .sw_o             (sw_o)
   );

   input_conditioner #(.DEBOUNCE_CYCLES(1), .SW_WIDTH(16)) dut1 (
      .clk              (clk),
      .reset            (reset),
      .run_i            (run_i),
      .continue_i       (continue_i),
      .sw_i             (sw_i),
      .run_o            (run1_o),
      .run_pulse_o      (run1_pulse_o),
      .continue_o       (cont1_o),
      .continue_pulse_o (cont1_pulse_o),
      .sw_o             (sw1_o)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are then sampled 1 time unit later and
   // any new input value is applied before the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; run_i = 1'b0; continue_i = 1'b0; sw_i = 16'h0000;
      tick();
      tick();
      n_checks++;
      if ({run_o, run_pulse_o, continue_o, continue_pulse_o, sw_o} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {run_o, run_pulse_o, continue_o, continue_pulse_o, sw_o});
      end
      reset = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         n_checks++;
         if ({run_o, run_pulse_o, continue_o, continue_pulse_o, sw_o} !== 20'h0) begin
            n_fail++;
            $display("FAIL idle_outputs cycle %0d: got %h expected 0", e,
                     {run_o, run_pulse_o, continue_o, continue_pulse_o, sw_o});
         end
      end
      sw_i = 16'h1242;
      tick();
      n_checks++;
      if (sw_o !== 16'h0000) begin
         n_fail++;
         $display("FAIL sw_latency_e0: got %h expected 0000", sw_o);
      end
      tick();
      n_checks++;
      if (sw_o !== 16'h1242) begin
         n_fail++;
         $display("FAIL sw_latency_e1: got %h expected 1242", sw_o);
      end
   endtask

   task automatic test_clean_press();
      run_i = 1'b1;
      for (int e = 0; e < 20; e++) begin
         tick();
         n_checks++;
         if (run_o !== (e >= 5) || run_pulse_o !== (e == 5)) begin
            n_fail++;
            $display("FAIL clean_press edge %0d: run_o=%b pulse=%b expected %b %b",
                     e, run_o, run_pulse_o, (e >= 5), (e == 5));
         end
         n_checks++;
         if (continue_o !== 1'b0 || continue_pulse_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_press_other edge %0d: continue=%b pulse=%b expected 0 0",
                     e, continue_o, continue_pulse_o);
         end
      end
      run_i = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_checks++;
         if (run_o !== (e < 5) || run_pulse_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_release edge %0d: run_o=%b pulse=%b expected %b 0",
                     e, run_o, run_pulse_o, (e < 5));
         end
      end
   endtask

   task automatic test_bouncy_press();
      logic [3:0] bounce;
      bounce = 4'b0101;  // applied LSB first: 1,0,1,0
      for (int k = 0; k < 4; k++) begin
         continue_i = bounce[k];
         tick();
         n_checks++;
         if (continue_o !== 1'b0 || continue_pulse_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_phase step %0d: continue=%b pulse=%b expected 0 0",
                     k, continue_o, continue_pulse_o);
         end
      end
      continue_i = 1'b1;
      for (int e = 0; e < 15; e++) begin
         tick();
         n_checks++;
         if (continue_o !== (e >= 5) || continue_pulse_o !== (e == 5)) begin
            n_fail++;
            $display("FAIL bouncy_press edge %0d: continue=%b pulse=%b expected %b %b",
                     e, continue_o, continue_pulse_o, (e >= 5), (e == 5));
         end
      end
      continue_i = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_checks++;
         if (continue_o !== (e < 5) || continue_pulse_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bouncy_release edge %0d: continue=%b pulse=%b expected %b 0",
                     e, continue_o, continue_pulse_o, (e < 5));
         end
      end
   endtask

   task automatic test_short_glitch();
      run_i = 1'b1;
      for (int e = 0; e < 12; e++) begin
         if (e == 3) run_i = 1'b0;
         tick();
         n_checks++;
         if (run_o !== 1'b0 || run_pulse_o !== 1'b0) begin
            n_fail++;
            $display("FAIL short_glitch edge %0d: run_o=%b pulse=%b expected 0 0",
                     e, run_o, run_pulse_o);
         end
      end
   endtask

   task automatic test_simultaneous();
      run_i = 1'b1;
      continue_i = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_checks++;
         if ({run_o, run_pulse_o, continue_o, continue_pulse_o} !==
             {(e >= 5), (e == 5), (e >= 5), (e == 5)}) begin
            n_fail++;
            $display("FAIL simultaneous edge %0d: got %b expected %b", e,
                     {run_o, run_pulse_o, continue_o, continue_pulse_o},
                     {(e >= 5), (e == 5), (e >= 5), (e == 5)});
         end
      end
      run_i = 1'b0;
      continue_i = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_checks++;
         if ({run_o, run_pulse_o, continue_o, continue_pulse_o} !==
             {(e < 5), 1'b0, (e < 5), 1'b0}) begin
            n_fail++;
            $display("FAIL simultaneous_release edge %0d: got %b expected %b", e,
                     {run_o, run_pulse_o, continue_o, continue_pulse_o},
                     {(e < 5), 1'b0, (e < 5), 1'b0});
         end
      end
   endtask

   task automatic test_reset_mid_debounce();
      run_i = 1'b1;
      for (int e = 0; e < 3; e++) begin
         tick();
         n_checks++;
         if (run_o !== 1'b0 || run_pulse_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset d4 edge %0d: run_o=%b pulse=%b expected 0 0",
                     e, run_o, run_pulse_o);
         end
         n_checks++;
         if (run1_o !== (e >= 2) || run1_pulse_o !== (e == 2)) begin
            n_fail++;
            $display("FAIL pre_reset d1 edge %0d: run_o=%b pulse=%b expected %b %b",
                     e, run1_o, run1_pulse_o, (e >= 2), (e == 2));
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({run_o, run_pulse_o, continue_o, continue_pulse_o, sw_o} !== 20'h0) begin
         n_fail++;
         $display("FAIL mid_reset d4: got %h expected 0",
                  {run_o, run_pulse_o, continue_o, continue_pulse_o, sw_o});
      end
      n_checks++;
      if ({run1_o, run1_pulse_o, cont1_o, cont1_pulse_o, sw1_o} !== 20'h0) begin
         n_fail++;
         $display("FAIL mid_reset d1: got %h expected 0",
                  {run1_o, run1_pulse_o, cont1_o, cont1_pulse_o, sw1_o});
      end
      for (int e = 0; e < 10; e++) begin
         tick();
         n_checks++;
         if (run_o !== (e >= 5) || run_pulse_o !== (e == 5)) begin
            n_fail++;
            $display("FAIL post_reset d4 edge %0d: run_o=%b pulse=%b expected %b %b",
                     e, run_o, run_pulse_o, (e >= 5), (e == 5));
         end
         n_checks++;
         if (run1_o !== (e >= 2) || run1_pulse_o !== (e == 2)) begin
            n_fail++;
            $display("FAIL post_reset d1 edge %0d: run_o=%b pulse=%b expected %b %b",
                     e, run1_o, run1_pulse_o, (e >= 2), (e == 2));
         end
         n_checks++;
         if (sw_o !== ((e >= 1) ? 16'h1242 : 16'h0000)) begin
            n_fail++;
            $display("FAIL post_reset sw edge %0d: got %h expected %h",
                     e, sw_o, ((e >= 1) ? 16'h1242 : 16'h0000));
         end
      end
      run_i = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      run_i = 1'b0;
      continue_i = 1'b0;
      sw_i = 16'h0000;
      test_reset();
      test_clean_press();
      test_bouncy_press();
      test_short_glitch();
      test_simultaneous();
      test_reset_mid_debounce();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage for the LC-3 board top level. It takes the raw, asynchronous, bouncing `run_i` / `continue_i` push-buttons and `sw_i` slide switches, then delivers clean, clock-synchronous signals to the processor.
- Buttons get a 2-FF synchronizer, a per-button debounce counter, and a rising-edge one-shot.
- Switches get a 2-FF synchronizer only.

The block sits directly upstream of the processor top, and its outputs drive the processor's run, continue and switch inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive cycles a synchronized button must differ from its debounced level before that level flips. Legal range ≥ 1.
- `SW_WIDTH`, default 16: switch bus width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run_i`  in  1  raw run button, asynchronous, active-high.
- `continue_i`  in  1  raw continue button, asynchronous, active-high.
- `sw_i`  in  SW_WIDTH  raw slide switches, asynchronous.
- `run_o`  out  1  debounced run level.
- `run_pulse_o`  out  1  one-cycle pulse on debounced run rising edge.
- `continue_o`  out  1  debounced continue level.
- `continue_pulse_o`  out  1  one-cycle pulse on debounced continue rising edge.
- `sw_o`  out  SW_WIDTH  synchronized switches.

## Operation
- Reset values:
  - all synchronizer flops 0;
  - debounce counters 0;
  - `run_o`, `continue_o`, both pulses 0;
  - `sw_o` all 0.
- Synchronizer: each raw input passes through two back-to-back flops (s1, s2). Nothing but s2 is used downstream.
- Debounce, per button, fully independent:
  - counter width = $clog2(DEBOUNCE_CYCLES+1); it never wraps.
  - If s2 == debounced level: counter cleared to 0 on that edge.
  - If s2 != debounced level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If s2 != debounced level and counter == DEBOUNCE_CYCLES-1: debounced level toggles and counter clears.
  - Any single-cycle return of s2 to the debounced level (a bounce) restarts the count from 0.
- Pulse:
  - `*_pulse_o` is a registered output, high for exactly the one cycle in which the debounced level transitions 0→1.
  - No pulse is produced on a 1→0 transition.
  - Holding the button produces exactly one pulse per press.
- Switches: `sw_o` equals s2 of `sw_i`, with no debounce.
- Both buttons may change in the same cycle. Each follows its own rules, and both pulses may assert together.
- Reset asserted mid-count or mid-pulse: on that edge every register returns to its reset value, and any pending count is discarded. After release, an input already held high debounces from scratch.

## Timing
- Input changes before edge E0 and is then held.
- s1 captures at E0; s2 captures at E1.
- Mismatch is first counted at E2.
- The debounced level flips at edge E(DEBOUNCE_CYCLES+1).
- The pulse is high for the cycle immediately after that edge, i.e. concurrent with the first cycle of the new level.
- Total press-to-pulse latency: DEBOUNCE_CYCLES+2 edges including the sync stages. With DEBOUNCE_CYCLES=1, the level flips at E2.
- Release latency is identical, with no pulse.
- Switch latency: 2 edges, from `sw_i` change to `sw_o`.
- Reset takes effect on the first rising edge with `reset`=1, and outputs read reset values in the following cycle.
- There is no combinational path from any input to any output.

## Test plan
Use DEBOUNCE_CYCLES=4 unless stated otherwise.
- Reset, then idle inputs with `sw_i`=16'h0000 → all outputs 0 for 20 cycles. Then `sw_i`=16'h1242 → `sw_o`=16'h1242 exactly 2 edges later, with no intermediate value.
- Clean press: `run_i` 0→1, held 20 cycles.
  - `run_o` rises at E5.
  - `run_pulse_o` is high for exactly one cycle at E5, then 0 while the button stays held.
  - Release: `run_o` falls at E5 after release, with no pulse.
- Bouncy press: `continue_i` toggles 1,0,1,0 in single cycles, then holds 1 → no change during the bounce. `continue_o` rises 6 edges after the final 0→1, with exactly one pulse.
- Short glitch: `run_i` high for 3 cycles (< DEBOUNCE_CYCLES), then low → `run_o` and `run_pulse_o` stay 0 throughout.
- Simultaneous press: `run_i` and `continue_i` rise on the same cycle → both levels rise and both pulses fire on the same edge (E5), each for one cycle.
- Reset mid-debounce:
  - `run_i` high; assert `reset` at E3 for 1 cycle → all outputs 0.
  - With `run_i` still held, `run_o` rises 6 edges after reset deassertion, with one pulse.
  - Repeat with DEBOUNCE_CYCLES=1 → rise at E2.
